// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the pipeline and the iterative RV32M
// multiply/divide unit. The pipeline side is the master; the unit is the slave.
interface muldiv_seq_if #(
   parameter int DATA_W = 32
);
   logic              start;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] SrcA;
   logic [DATA_W-1:0] SrcB;
   logic              flush;
   logic              Stall;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] Result;

   modport master (
      output start, funct3, SrcA, SrcB, flush,
      input  Stall, busy, done, Result
   );

   modport slave (
      input  start, funct3, SrcA, SrcB, flush,
      output Stall, busy, done, Result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use shift-add on operand magnitudes with a 2*DATA_W product and
// a final sign fix-up. Divides use restoring division on magnitudes. Divide by
// zero and signed overflow skip the iteration phase and finish immediately.
module muldiv_seq #(
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
   localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nx;

   logic [2:0]        op_q;
   logic [DATA_W-1:0] mag_b_q;
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;
   logic              neg_q;
   logic              neg_rem_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [DATA_W-1:0] res_q;

   logic accept, finish;
   logic stall_c, busy_c, done_c;

   // Two's-complement negate when n is set (DATA_W wide).
   function automatic logic [DATA_W-1:0] neg_w(input logic n, input logic [DATA_W-1:0] v);
      return n ? (~v + DATA_W'(1)) : v;
   endfunction

   // Two's-complement negate when n is set (2*DATA_W wide).
   function automatic logic [2*DATA_W-1:0] neg_2w(input logic n, input logic [2*DATA_W-1:0] v);
      return n ? (~v + (2*DATA_W)'(1)) : v;
   endfunction

   // ---------------- operand decode at accept ----------------
   logic signed [DATA_W-1:0] src_a_s, src_b_s;
   logic                     a_signed, b_signed, sign_a, sign_b;
   logic                     in_div, div_zero, div_ovf, bypass;
   logic [DATA_W-1:0]        mag_a_in, mag_b_in, bypass_res;

   // Classify the incoming request and form operand magnitudes.
   always_comb begin
      src_a_s    = bus.SrcA;
      src_b_s    = bus.SrcB;
      in_div     = bus.funct3[2];
      a_signed   = (bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110});
      b_signed   = (bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110});
      sign_a     = a_signed && (src_a_s < 0);
      sign_b     = b_signed && (src_b_s < 0);
      mag_a_in   = neg_w(sign_a, bus.SrcA);
      mag_b_in   = neg_w(sign_b, bus.SrcB);
      div_zero   = in_div && (bus.SrcB == '0);
      div_ovf    = in_div && !bus.funct3[0] && (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
      bypass     = div_zero || div_ovf;
      bypass_res = '0;
      if (div_zero)
         bypass_res = bus.funct3[1] ? bus.SrcA : '1;
      else
         bypass_res = bus.funct3[1] ? '0 : bus.SrcA;
   end

   // ---------------- one radix-2 iteration ----------------
   logic [DATA_W:0]     mul_sum, div_shift, div_trial;
   logic [DATA_W-1:0]   hi_nx, lo_nx, final_res;
   logic [2*DATA_W-1:0] prod;

   // Next working state for this CALC cycle and the result it would produce.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
      div_shift = {hi_q, lo_q[DATA_W-1]};
      div_trial = div_shift - {1'b0, mag_b_q};
      if (op_q[2]) begin
         if (!div_trial[DATA_W]) begin
            hi_nx = div_trial[DATA_W-1:0];
            lo_nx = {lo_q[DATA_W-2:0], 1'b1};
         end else begin
            hi_nx = div_shift[DATA_W-1:0];
            lo_nx = {lo_q[DATA_W-2:0], 1'b0};
         end
      end else begin
         hi_nx = mul_sum[DATA_W:1];
         lo_nx = {mul_sum[0], lo_q[DATA_W-1:1]};
      end
      prod = neg_2w(neg_q, {hi_nx, lo_nx});
      case (op_q)
         3'b000:                 final_res = prod[DATA_W-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod[2*DATA_W-1:DATA_W];
         3'b100, 3'b101:         final_res = neg_w(neg_q, lo_nx);
         default:                final_res = neg_w(neg_rem_q, hi_nx);
      endcase
   end

   // ---------------- control ----------------
   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      finish   = 1'b0;
      stall_c  = 1'b0;
      busy_c   = 1'b0;
      done_c   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               accept   = 1'b1;
               stall_c  = 1'b1;
               state_nx = bypass ? DONE : CALC;
            end
         end
         CALC: begin
            stall_c = 1'b1;
            busy_c  = 1'b1;
            if (bus.flush) begin
               state_nx = IDLE;
            end else if (cnt_q == LAST_CNT) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE: begin
            done_c   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operand capture, iteration registers and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         mag_b_q   <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         res_q     <= '0;
      end else if (accept) begin
         op_q      <= bus.funct3;
         mag_b_q   <= mag_b_in;
         hi_q      <= '0;
         lo_q      <= mag_a_in;
         neg_q     <= sign_a ^ sign_b;
         neg_rem_q <= sign_a;
         cnt_q     <= '0;
         if (bypass) res_q <= bypass_res;
      end else if (state == CALC && !bus.flush) begin
         hi_q  <= hi_nx;
         lo_q  <= lo_nx;
         cnt_q <= cnt_q + CNT_W'(1);
         if (finish) res_q <= final_res;
      end
   end

   assign bus.Stall  = stall_c;
   assign bus.busy   = busy_c;
   assign bus.done   = done_c;
   assign bus.Result = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: RV32M operations with hand-computed results,
// latency, bypass cases, flush and asynchronous reset abort.
module tb_muldiv_seq;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   muldiv_seq_if #(.DATA_W(32)) bus ();

   muldiv_seq #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic watch_no_done(input int cycles, input string tag);
      int seen;
      seen = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk(tag, seen, 0);
   endtask

   // Issue one operation and follow it to its done pulse.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      bit got_done;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = f3;
      bus.SrcA   = a;
      bus.SrcB   = b;
      #1;
      chk({tag, "_stall_req"}, {31'b0, bus.Stall}, 32'd1);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.SrcA  = ~a;
      bus.SrcB  = 32'd5;
      lat      = 0;
      got_done = 1'b0;
      while (lat < 100 && !got_done) begin
         @(negedge clk);
         lat++;
         if (lat == 1)
            chk({tag, "_busy1"}, {31'b0, bus.busy}, (exp_lat > 1) ? 32'd1 : 32'd0);
         if (bus.done) got_done = 1'b1;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_result"}, bus.Result, exp);
      chk({tag, "_stall_done"}, {31'b0, bus.Stall}, 32'd0);
      @(negedge clk);
      chk({tag, "_done_once"}, {31'b0, bus.done}, 32'd0);
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b000;
      bus.SrcA   = 32'h0;
      bus.SrcB   = 32'h0;

      repeat (3) @(negedge clk);
      chk("rst_result", bus.Result, 32'h0);
      chk("rst_busy",   {31'b0, bus.busy},  32'd0);
      chk("rst_done",   {31'b0, bus.done},  32'd0);
      chk("rst_stall",  {31'b0, bus.Stall}, 32'd0);
      rst_n = 1'b1;

      run_op("mul",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
      run_op("mulh",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhu",   3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
      run_op("mulhsu",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("div",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu",    3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("remu",    3'b111, 32'd100,      32'd7,        32'd2,        33);

      // Flush in the 10th CALC cycle of a MUL; Result must keep 2.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.SrcA   = 32'd3;
      bus.SrcB   = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      @(negedge clk);
      chk("flush_busy_before", {31'b0, bus.busy}, 32'd1);
      chk("flush_result_hold", bus.Result, 32'd2);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_after",  {31'b0, bus.busy},  32'd0);
      chk("flush_stall_after", {31'b0, bus.Stall}, 32'd0);
      chk("flush_result",      bus.Result, 32'd2);
      watch_no_done(40, "flush_no_done");

      // start together with flush in IDLE is not accepted.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.flush  = 1'b1;
      bus.funct3 = 3'b101;
      bus.SrcA   = 32'd9;
      bus.SrcB   = 32'd0;
      #1;
      chk("idle_flush_stall", {31'b0, bus.Stall}, 32'd0);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_busy", {31'b0, bus.busy}, 32'd0);
      watch_no_done(40, "idle_flush_no_done");
      chk("idle_flush_result", bus.Result, 32'd2);

      run_op("divu_z",  3'b101, 32'h00001234, 32'h0,        32'hFFFFFFFF, 1);
      run_op("remu_z",  3'b111, 32'h00001234, 32'h0,        32'h00001234, 1);
      run_op("div_z",   3'b100, 32'hFFFFFF00, 32'h0,        32'hFFFFFFFF, 1);
      run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
      run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

      // Asynchronous reset in the 20th CALC cycle.
      @(negedge clk);
      bus.start  = 1'b1;
      bus.funct3 = 3'b000;
      bus.SrcA   = 32'd3;
      bus.SrcB   = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      @(negedge clk);
      chk("arst_busy_before", {31'b0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy",   {31'b0, bus.busy},  32'd0);
      chk("arst_result", bus.Result, 32'h0);
      chk("arst_done",   {31'b0, bus.done},  32'd0);
      chk("arst_stall",  {31'b0, bus.Stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_done(5, "arst_no_done");

      run_op("mul_after_rst", 3'b000, 32'd3, 32'd5, 32'd15, 33);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
